ssg_scan: RTL and testbench

Four-digit, time-multiplexed seven-segment display driver for the board top level, directly upstream of the `an`/`ssg` pins. It latches a 16-bit hex value with per-digit decimal-point, blank and leading-zero controls on a `load` strobe. It scans one digit at a time at a programmable refresh rate and drives active-low anode and segment outputs. Display content changes only at digit boundaries, so the displayed value never glitches mid-slot.

---
 rtl/ssg_scan.sv | 119 +++++++++++
 tb/tb_ssg_scan.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssg_scan.sv
// Four-digit multiplexed seven-segment driver: shadows a hex value on load and
// scans one active-low digit per REFRESH_DIV cycles, updating only at slot boundaries.
module ssg_scan #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [7:0]  ssg,
    output logic        frame
);

    localparam int unsigned   CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   sh_value_q, sh_value_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_blank_q, sh_blank_d;
    logic          sh_lz_q, sh_lz_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    ssg_q, ssg_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic [3:0]    nib;
    logic [3:0]    lz_mask;
    logic          dark;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        sh_value_d = load ? value    : sh_value_q;
        sh_dp_d    = load ? dp       : sh_dp_q;
        sh_blank_d = load ? blank    : sh_blank_q;
        sh_lz_d    = load ? lz_blank : sh_lz_q;

        // lz_mask[k] set when nibbles 3..k are all zero; digit 0 is never suppressed
        lz_mask[3] = (sh_value_q[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] & (sh_value_q[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] & (sh_value_q[7:4] == 4'h0);
        lz_mask[0] = 1'b0;

        nib  = sh_value_q[{idx_d, 2'b00} +: 4];
        dark = sh_blank_q[idx_d] | (sh_lz_q & lz_mask[idx_d]);

        an_d    = an_q;
        ssg_d   = ssg_q;
        frame_d = 1'b0;
        if (tick) begin
            frame_d = (idx_q == 2'd3);
            if (dark) begin
                an_d  = '1;
                ssg_d = '1;
            end else begin
                an_d  = ~(4'b0001 << idx_d);
                ssg_d = {~sh_dp_q[idx_d], ~hex_seg(nib)};
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            sh_value_q <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            sh_lz_q    <= 1'b0;
            an_q       <= '1;
            ssg_q      <= '1;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_value_q <= sh_value_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            sh_lz_q    <= sh_lz_d;
            an_q       <= an_d;
            ssg_q      <= ssg_d;
            frame_q    <= frame_d;
        end
    end

    assign an    = an_q;
    assign ssg   = ssg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_ssg_scan.sv
// Bench for ssg_scan: per-cycle comparison against an edge-count display model,
// plus directed slot expectations for each scenario.
module tb_ssg_scan;

    localparam int DIV = 4;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [7:0]  ssg;
    logic        frame;

    int checks = 0;
    int errors = 0;

    ssg_scan #(.REFRESH_DIV(DIV)) dut (
        .mclk(mclk), .rst(rst), .load(load), .value(value), .dp(dp),
        .blank(blank), .lz_blank(lz_blank), .an(an), .ssg(ssg), .frame(frame)
    );

    always #5 mclk = ~mclk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: c = edges since reset released; slot boundaries at every multiple of DIV.
    int unsigned c = 0;
    int          cur_k = 0;
    logic        m_tick = 1'b0;
    logic [15:0] s_val = '0;
    logic [3:0]  s_dp = '0, s_blank = '0;
    logic        s_lz = 1'b0;
    logic [3:0]  exp_an = '1;
    logic [7:0]  exp_ssg = '1;
    logic        exp_frame = 1'b0;

    task automatic step();
        int k;
        int nib;
        @(posedge mclk);
        m_tick = 1'b0;
        if (rst) begin
            c = 0;
            s_val = '0; s_dp = '0; s_blank = '0; s_lz = 1'b0;
            exp_an = '1; exp_ssg = '1; exp_frame = 1'b0;
        end else begin
            c++;
            exp_frame = 1'b0;
            if (c % DIV == 0) begin
                k = int'((c / DIV - 1) % 4);
                cur_k = k;
                m_tick = 1'b1;
                if (s_blank[k] || (s_lz && k >= 1 && (s_val >> (4 * k)) == 0)) begin
                    exp_an = '1;
                    exp_ssg = '1;
                end else begin
                    nib = int'((s_val >> (4 * k)) & 16'hF);
                    exp_an = 4'hF;
                    exp_an[k] = 1'b0;
                    exp_ssg = {~s_dp[k], ~seg_tab[nib]};
                end
                exp_frame = (k == 0);
            end
            if (load) begin
                s_val = value; s_dp = dp; s_blank = blank; s_lz = lz_blank;
            end
        end
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] b, input logic lz);
        value = v; dp = d; blank = b; lz_blank = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if (an !== 4'hF || ssg !== 8'hFF || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: an=%b ssg=%h frame=%b, expected an=1111 ssg=ff frame=0", an, ssg, frame);
        end
        rst = 1'b0;
        for (int e = 1; e <= DIV + 1; e++) begin
            step();
            checks++;
            if (an !== exp_an || ssg !== exp_ssg || frame !== exp_frame) begin
                errors++;
                $display("FAIL reset_model edge %0d: an=%b ssg=%h frame=%b, expected an=%b ssg=%h frame=%b",
                         e, an, ssg, frame, exp_an, exp_ssg, exp_frame);
            end
            checks++;
            if (e < DIV && (an !== 4'hF || ssg !== 8'hFF || frame !== 1'b0)) begin
                errors++;
                $display("FAIL reset_idle edge %0d: an=%b ssg=%h frame=%b, expected an=1111 ssg=ff frame=0", e, an, ssg, frame);
            end else if (e == DIV && (an !== 4'b1110 || ssg !== 8'hC0 || frame !== 1'b1)) begin
                errors++;
                $display("FAIL reset_first_tick: an=%b ssg=%h frame=%b, expected an=1110 ssg=c0 frame=1", an, ssg, frame);
            end else if (e == DIV + 1 && frame !== 1'b0) begin
                errors++;
                $display("FAIL reset_frame_width: frame=%b, expected 0", frame);
            end
        end
    endtask

    // Loads, lets every digit refresh, then checks one full frame of slots against a table.
    task automatic run_slots(input string name, input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] b, input logic lz,
                             input logic [3:0] w_an [4], input logic [7:0] w_ssg [4]);
        do_load(v, d, b, lz);
        repeat (9 * DIV) begin
            step();
            checks++;
            if (an !== exp_an || ssg !== exp_ssg || frame !== exp_frame) begin
                errors++;
                $display("FAIL %s_model c=%0d: an=%b ssg=%h frame=%b, expected an=%b ssg=%h frame=%b",
                         name, c, an, ssg, frame, exp_an, exp_ssg, exp_frame);
            end
            if (m_tick && c > 0) begin
                checks++;
                if (an !== w_an[cur_k] || ssg !== w_ssg[cur_k]) begin
                    errors++;
                    $display("FAIL %s_slot%0d: an=%b ssg=%h, expected an=%b ssg=%h",
                             name, cur_k, an, ssg, w_an[cur_k], w_ssg[cur_k]);
                end
            end
        end
    endtask

    task automatic test_hex_scan();
        logic [3:0] wa [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] ws [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        run_slots("hex_scan", 16'h12AF, 4'b0000, 4'b0000, 1'b0, wa, ws);
    endtask

    task automatic test_leading_zeros();
        logic [3:0] wa [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        logic [7:0] ws [4] = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] wz [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        run_slots("lz_0005", 16'h0005, 4'b0000, 4'b0000, 1'b1, wa, ws);
        run_slots("lz_0000", 16'h0000, 4'b0000, 4'b0000, 1'b1, wa, wz);
    endtask

    task automatic test_dp_blank();
        // nibble k of 16'h1234 drives digit k: digit1='3', digit2='2' with dp, digit3='1'
        logic [3:0] wa [4] = '{4'b1111, 4'b1101, 4'b1011, 4'b0111};
        logic [7:0] ws [4] = '{8'hFF, 8'hB0, 8'h24, 8'hF9};
        run_slots("dp_blank", 16'h1234, 4'b0100, 4'b0001, 1'b0, wa, ws);
    endtask

    task automatic test_load_on_tick();
        int last;
        int pulses;
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 100 && !(c >= unsigned'(5 * DIV) && (c + 1) % DIV == 0); i++) begin
            step();
            checks++;
            if (an !== exp_an || ssg !== exp_ssg || frame !== exp_frame) begin
                errors++;
                $display("FAIL lot_align_model c=%0d: an=%b ssg=%h frame=%b, expected an=%b ssg=%h frame=%b",
                         c, an, ssg, frame, exp_an, exp_ssg, exp_frame);
            end
        end
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        checks++;
        if (!m_tick || ssg !== 8'hF9) begin
            errors++;
            $display("FAIL lot_old_digit: tick=%b ssg=%h, expected tick=1 ssg=f9", m_tick, ssg);
        end
        repeat (DIV) begin
            step();
            checks++;
            if (an !== exp_an || ssg !== exp_ssg || frame !== exp_frame) begin
                errors++;
                $display("FAIL lot_model c=%0d: an=%b ssg=%h frame=%b, expected an=%b ssg=%h frame=%b",
                         c, an, ssg, frame, exp_an, exp_ssg, exp_frame);
            end
        end
        checks++;
        if (!m_tick || ssg !== 8'hA4) begin
            errors++;
            $display("FAIL lot_new_digit: tick=%b ssg=%h, expected tick=1 ssg=a4", m_tick, ssg);
        end
        last = -1;
        pulses = 0;
        repeat (10 * DIV + 2) begin
            step();
            if (frame === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    checks++;
                    if (int'(c) - last !== 4 * DIV) begin
                        errors++;
                        $display("FAIL frame_period: got %0d cycles, expected %0d", int'(c) - last, 4 * DIV);
                    end
                end
                last = int'(c);
            end
        end
        checks++;
        if (pulses < 2) begin
            errors++;
            $display("FAIL frame_pulses: got %0d pulses, expected at least 2", pulses);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic found;
        found = 1'b0;
        do_load(16'hBEEF, 4'b1010, 4'b0000, 1'b0);
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (m_tick && cur_k == 2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rms_align: slot 2 not reached, expected within 100 cycles");
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (an !== 4'hF || ssg !== 8'hFF || frame !== 1'b0) begin
            errors++;
            $display("FAIL rms_reset: an=%b ssg=%h frame=%b, expected an=1111 ssg=ff frame=0", an, ssg, frame);
        end
        repeat (DIV - 1) step();
        checks++;
        if (an !== 4'hF || ssg !== 8'hFF || frame !== 1'b0) begin
            errors++;
            $display("FAIL rms_idle: an=%b ssg=%h frame=%b, expected an=1111 ssg=ff frame=0", an, ssg, frame);
        end
        step();
        checks++;
        if (an !== 4'b1110 || ssg !== 8'hC0 || frame !== 1'b1) begin
            errors++;
            $display("FAIL rms_restart: an=%b ssg=%h frame=%b, expected an=1110 ssg=c0 frame=1", an, ssg, frame);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            load = ($urandom_range(0, 5) == 0);
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp = 4'($urandom);
            blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            lz_blank = 1'($urandom);
            step();
            checks++;
            if (an !== exp_an || ssg !== exp_ssg || frame !== exp_frame) begin
                errors++;
                $display("FAIL random_model c=%0d: an=%b ssg=%h frame=%b, expected an=%b ssg=%h frame=%b",
                         c, an, ssg, frame, exp_an, exp_ssg, exp_frame);
            end
        end
        rst = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hex_scan();
        test_leading_zeros();
        test_dp_blank();
        test_load_on_tick();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
